// File: rtl/sigma_delta_pkg.sv
// Shared types and constants for the multi-channel sigma-delta modulator.
// Holds the order-2 integrator width offsets and the frame-counter helpers.
package sigma_delta_pkg;

  // Headroom bits added to VALUE_WIDTH for the two order-2 integrators.
  localparam int unsigned I1_EXTRA_BITS = 3;
  localparam int unsigned I2_EXTRA_BITS = 5;

  // Shadow register occupancy: FREE means value_ready is high.
  typedef enum logic {
    SHADOW_FREE    = 1'b0,
    SHADOW_PENDING = 1'b1
  } shadow_state_e;

  // Per-cycle frame events derived from the frame counter.
  typedef struct packed {
    logic wrap;   // enabled cycle with the counter at its last value
    logic start;  // enabled cycle with the counter at zero
  } frame_evt_t;

  function automatic frame_evt_t frame_events(input logic enable,
                                              input logic at_first,
                                              input logic at_last);
    frame_evt_t evt;
    evt.start = enable & at_first;
    evt.wrap  = enable & at_last;
    return evt;
  endfunction

endpackage

// File: rtl/sigma_delta_if.sv
// Value-update handshake between a producer and sigma_delta_mc.
// Channel k occupies value_data[k*VALUE_WIDTH +: VALUE_WIDTH], unsigned.
interface sigma_delta_if #(
  parameter int VALUE_WIDTH = 8,
  parameter int CHANNELS    = 4
) ();

  logic [CHANNELS*VALUE_WIDTH-1:0] value_data;
  logic                            value_valid;
  logic                            value_ready;

  modport master (
    output value_data,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_data,
    input  value_valid,
    output value_ready
  );

endinterface

// File: rtl/sigma_delta_channel.sv
// One modulator loop: first order by default, second order when the macro
// SIGMA_DELTA_ORDER2_EN is defined. Output is forced to 0 while disabled.
module sigma_delta_channel
  import sigma_delta_pkg::*;
#(
  parameter int VALUE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic                   sigma_delta
);

  logic sd_q, sd_d;

`ifdef SIGMA_DELTA_ORDER2_EN
  localparam int I1_W = VALUE_WIDTH + I1_EXTRA_BITS;
  localparam int I2_W = VALUE_WIDTH + I2_EXTRA_BITS;

  logic signed [I1_W-1:0] i1_q, i1_d;
  logic signed [I2_W-1:0] i2_q, i2_d;
  logic                   y_q, y_d;
  logic signed [I1_W-1:0] x_ext;
  logic signed [I1_W-1:0] fb1;
  logic signed [I2_W-1:0] fb2;

  // Feedback is full scale (2**VALUE_WIDTH) when the last decision was 1.
  assign x_ext = {{I1_EXTRA_BITS{1'b0}}, value};
  assign fb1   = {{(I1_EXTRA_BITS-1){1'b0}}, y_q, {VALUE_WIDTH{1'b0}}};
  assign fb2   = {{(I2_EXTRA_BITS-1){1'b0}}, y_q, {VALUE_WIDTH{1'b0}}};

  always_comb begin
    i1_d = i1_q;
    i2_d = i2_q;
    y_d  = y_q;
    sd_d = 1'b0;
    if (enable) begin
      i1_d = i1_q + x_ext - fb1;
      i2_d = i2_q + {{(I2_EXTRA_BITS-I1_EXTRA_BITS){i1_d[I1_W-1]}}, i1_d} - fb2;
      y_d  = ~i2_d[I2_W-1];
      sd_d = y_d;
    end
  end

  // The loop decision y_q is held while disabled; only the port is gated.
  always_ff @(posedge clk) begin
    if (reset) begin
      i1_q <= '0;
      i2_q <= '0;
      y_q  <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      y_q  <= y_d;
      sd_q <= sd_d;
    end
  end
`else
  logic [VALUE_WIDTH-1:0] acc_q, acc_d;
  logic [VALUE_WIDTH:0]   sum;

  // The carry out of the accumulator is the output bit.
  assign sum = {1'b0, acc_q} + {1'b0, value};

  always_comb begin
    acc_d = acc_q;
    sd_d  = 1'b0;
    if (enable) begin
      acc_d = sum[VALUE_WIDTH-1:0];
      sd_d  = sum[VALUE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sd_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sd_q  <= sd_d;
    end
  end
`endif

  assign sigma_delta = sd_q;

endmodule

// File: rtl/sigma_delta_mc.sv
// Multi-channel sigma-delta modulator: frame counter, shadow/active value
// handshake and CHANNELS loops. Loop order selected by SIGMA_DELTA_ORDER2_EN.
module sigma_delta_mc
  import sigma_delta_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int CHANNELS    = 4,
  parameter int FRAME_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  sigma_delta_if.slave        value_if,
  output logic [CHANNELS-1:0] sigma_delta,
  output logic                frame_start
);

  localparam int DATA_W = CHANNELS * VALUE_WIDTH;

  shadow_state_e          state_q, state_d;
  logic [FRAME_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]      shadow_q, shadow_d;
  logic [DATA_W-1:0]      active_q, active_d;
  logic                   frame_start_q, frame_start_d;
  frame_evt_t             evt;
  logic                   handshake;

  // Ready depends only on registered state, never on value_valid.
  assign value_if.value_ready = (state_q == SHADOW_FREE);
  assign handshake            = value_if.value_valid & value_if.value_ready;
  assign evt                  = frame_events(enable, cnt_q == '0, &cnt_q);

  always_comb begin
    // NOTE: every variable gets its default first, so no branch can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    frame_start_d = evt.start;

    if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end

    // A handshake on a wrap cycle lands in FREE and stays pending a full frame.
    case (state_q)
      SHADOW_FREE: begin
        if (handshake) begin
          shadow_d = value_if.value_data;
          state_d  = SHADOW_PENDING;
        end
      end
      SHADOW_PENDING: begin
        if (evt.wrap) begin
          active_d = shadow_q;
          state_d  = SHADOW_FREE;
        end
      end
      default: state_d = SHADOW_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q       <= SHADOW_FREE;
      cnt_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    sigma_delta_channel #(
      .VALUE_WIDTH(VALUE_WIDTH)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .value      (active_q[k*VALUE_WIDTH +: VALUE_WIDTH]),
      .sigma_delta(sigma_delta[k])
    );
  end

endmodule

// File: tb/tb_sigma_delta_mc.sv
// Directed/randomized bench for sigma_delta_mc with a behavioural model of
// the frame, handshake and modulator rules; order-2 checks under SIGMA_DELTA_ORDER2_EN.
module tb_sigma_delta_mc;

  localparam int VW   = 8;
  localparam int CH   = 4;
  localparam int FW   = 8;
  localparam int FS   = 1 << VW;
  localparam int FLEN = 1 << FW;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CH-1:0] sigma_delta;
  logic          frame_start;

  sigma_delta_if #(.VALUE_WIDTH(VW), .CHANNELS(CH)) vif ();

  sigma_delta_mc #(
    .VALUE_WIDTH(VW),
    .CHANNELS   (CH),
    .FRAME_WIDTH(FW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value_if   (vif),
    .sigma_delta(sigma_delta),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  int            m_cnt;
  bit            m_pending;
  int            m_shadow [CH];
  int            m_active [CH];
  int            m_acc    [CH];
  int            m_i1     [CH];
  int            m_i2     [CH];
  bit            m_y      [CH];
  logic [CH-1:0] m_sd;
  logic          m_fs;
  int            i1_min, i1_max, i2_min, i2_max;

  int ones [CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*VW-1:0] rand_vals();
    logic [CH*VW-1:0] v;
    for (int k = 0; k < CH; k++) v[k*VW +: VW] = VW'($urandom);
    return v;
  endfunction

  function automatic logic [CH*VW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [CH*VW-1:0] v;
    v = '0;
    v[0*VW +: VW] = VW'(a);
    v[1*VW +: VW] = VW'(b);
    v[2*VW +: VW] = VW'(c);
    v[3*VW +: VW] = VW'(d);
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit valid, input logic [CH*VW-1:0] data);
    bit hs;
    bit wrap;
    int s;
    int fb;
    if (rst) begin
      m_cnt = 0; m_pending = 0; m_sd = '0; m_fs = 1'b0;
      for (int k = 0; k < CH; k++) begin
        m_shadow[k] = 0; m_active[k] = 0; m_acc[k] = 0;
        m_i1[k] = 0; m_i2[k] = 0; m_y[k] = 0;
      end
      return;
    end
    hs   = valid && !m_pending;
    wrap = en && (m_cnt == FLEN - 1);
    m_fs = en && (m_cnt == 0);
    for (int k = 0; k < CH; k++) begin
      if (en) begin
`ifdef SIGMA_DELTA_ORDER2_EN
        fb = m_y[k] ? FS : 0;
        m_i1[k] = m_i1[k] + m_active[k] - fb;
        m_i2[k] = m_i2[k] + m_i1[k] - fb;
        m_y[k]  = (m_i2[k] >= 0);
        m_sd[k] = m_y[k];
        if (m_i1[k] < i1_min) i1_min = m_i1[k];
        if (m_i1[k] > i1_max) i1_max = m_i1[k];
        if (m_i2[k] < i2_min) i2_min = m_i2[k];
        if (m_i2[k] > i2_max) i2_max = m_i2[k];
`else
        s        = m_acc[k] + m_active[k];
        m_sd[k]  = (s >= FS);
        m_acc[k] = s % FS;
`endif
      end else begin
        m_sd[k] = 1'b0;
      end
    end
    if (wrap && m_pending) begin
      for (int k = 0; k < CH; k++) m_active[k] = m_shadow[k];
      m_pending = 0;
    end
    if (hs) begin
      for (int k = 0; k < CH; k++) m_shadow[k] = int'(data[k*VW +: VW]);
      m_pending = 1;
    end
    if (en) m_cnt = (m_cnt + 1) % FLEN;
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit rst, input bit en, input bit valid, input logic [CH*VW-1:0] data);
    reset           = rst;
    enable          = en;
    vif.value_valid = valid;
    vif.value_data  = data;
    model_step(rst, en, valid, data);
    @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++) if (sigma_delta[k] === 1'b1) ones[k]++;
    check("sigma_delta", 32'(sigma_delta), 32'(m_sd));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("value_ready", 32'(vif.value_ready), 32'(!m_pending));
  endtask

  task automatic clear_ones();
    for (int k = 0; k < CH; k++) ones[k] = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, '0);
  endtask

  // Counts ones over one whole frame, starting at the frame_start cycle.
  task automatic run_frame();
    int n;
    n = 0;
    do begin
      cyc(0, 1, 0, '0);
      n++;
    end while (frame_start !== 1'b1 && n < FLEN + 2);
    check("wait_frame_start", 32'(frame_start), 32'd1);
    for (int k = 0; k < CH; k++) ones[k] = (sigma_delta[k] === 1'b1) ? 1 : 0;
    run(FLEN - 1);
  endtask

  task automatic check_counts(input string tag, input logic [CH*VW-1:0] exp_vals);
    for (int k = 0; k < CH; k++)
      check($sformatf("%s_ch%0d", tag, k), 32'(ones[k]), 32'(exp_vals[k*VW +: VW]));
  endtask

  initial begin
    logic [CH*VW-1:0] base_v, a_v, b_v, c_v, d_v;
    int n;
    int lo, hi;

    i1_min = 0; i1_max = 0; i2_min = 0; i2_max = 0;
    reset = 1'b1; enable = 1'b0; vif.value_valid = 1'b0; vif.value_data = '0;
    clear_ones();

    // Reset state.
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    check("rst_ready", 32'(vif.value_ready), 32'd1);
    check("rst_sd",    32'(sigma_delta),     32'd0);
    check("rst_fs",    32'(frame_start),     32'd0);

    // Load {0,1,128,255} with enable low; it applies at the first wrap.
    base_v = pack4(0, 1, 128, 255);
    cyc(0, 0, 1, base_v);
    check("load_ready_low", 32'(vif.value_ready), 32'd0);
    run_frame();
`ifndef SIGMA_DELTA_ORDER2_EN
    check_counts("frame0_zero", '0);
`endif
    run_frame();
`ifndef SIGMA_DELTA_ORDER2_EN
    check_counts("frame1_base", base_v);
`endif

    // Back-to-back values with valid held high from mid-frame.
    a_v = rand_vals();
    b_v = rand_vals();
    clear_ones();
    run(40);
    cyc(0, 1, 1, a_v);
    check("a_accept_ready", 32'(vif.value_ready), 32'd0);
    n = 0;
    do begin
      cyc(0, 1, 1, b_v);
      n++;
    end while (vif.value_ready !== 1'b1 && n < FLEN + 4);
    check("b_stall_cycles", 32'(n), 32'(FLEN - 41));
`ifndef SIGMA_DELTA_ORDER2_EN
    check_counts("frame_a_arrival", base_v);
`endif
    clear_ones();
    cyc(0, 1, 1, b_v);
    check("b_accept_fs",    32'(frame_start),     32'd1);
    check("b_accept_ready", 32'(vif.value_ready), 32'd0);
    run(FLEN - 1);
`ifndef SIGMA_DELTA_ORDER2_EN
    check_counts("frame_a", a_v);
`endif

    // Handshake on the wrap cycle: not used in the next frame.
    c_v = rand_vals();
    clear_ones();
    run(FLEN - 1);
    cyc(0, 1, 1, c_v);
    check("wrap_hs_ready", 32'(vif.value_ready), 32'd0);
`ifndef SIGMA_DELTA_ORDER2_EN
    check_counts("frame_b", b_v);
`endif
    run_frame();
`ifndef SIGMA_DELTA_ORDER2_EN
    check_counts("frame_b_again", b_v);
`endif
    run_frame();
`ifndef SIGMA_DELTA_ORDER2_EN
    check_counts("frame_c", c_v);
`endif

    // Enable low for 37 cycles mid-frame.
    clear_ones();
    run(100);
    for (int i = 0; i < 37; i++) begin
      cyc(0, 0, 0, '0);
      check("pause_sd", 32'(sigma_delta), 32'd0);
      check("pause_fs", 32'(frame_start), 32'd0);
    end
    run(FLEN - 100);
`ifndef SIGMA_DELTA_ORDER2_EN
    check_counts("frame_c_paused", c_v);
`endif
    cyc(0, 1, 0, '0);
    check("resume_fs_on_time", 32'(frame_start), 32'd1);

    // Reset while an update is pending discards it.
    d_v = rand_vals() | pack4(1, 1, 1, 1);
    cyc(0, 1, 1, d_v);
    check("d_pending_ready", 32'(vif.value_ready), 32'd0);
    cyc(1, 1, 0, '0);
    check("rst_pend_ready", 32'(vif.value_ready), 32'd1);
    check("rst_pend_sd",    32'(sigma_delta),     32'd0);
    check("rst_pend_fs",    32'(frame_start),     32'd0);
    run_frame();
    run_frame();
    check_counts("after_rst_zero", '0);

`ifdef SIGMA_DELTA_ORDER2_EN
    // Second-order density for value 64 over 4096 cycles.
    cyc(0, 0, 1, pack4(64, 64, 64, 64));
    run_frame();
    clear_ones();
    run(4096);
    lo = (4096 * 245 + 999) / 1000;
    hi = (4096 * 255) / 1000;
    check("o2_density", 32'(ones[0] >= lo && ones[0] <= hi), 32'd1);
    check("o2_i1_range", 32'(i1_min >= -(1 << (VW + 2)) && i1_max <= (1 << (VW + 2)) - 1), 32'd1);
    check("o2_i2_range", 32'(i2_min >= -(1 << (VW + 4)) && i2_max <= (1 << (VW + 4)) - 1), 32'd1);
`else
    lo = 0;
    hi = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
